bitty_wb_bridge: RTL and testbench
==================================

BITTY_WB_BRIDGE -- requirements
Module: bitty_wb_bridge

Interface
REQ-001 SHALL have parameter BITS, default 16, giving the core data/instruction width (8..32).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, giving the instruction and result FIFO depth (power of 2, at least 2).
REQ-003 SHALL have parameter ADDR_BASE, default 32'h3000_0000, giving the Wishbone window base; the window is 256 bytes.
REQ-004 SHALL have port wb_clk_i, input, 1 bit: the only clock.
REQ-005 SHALL have port wb_rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have Wishbone slave ports: wbs_stb_i/wbs_cyc_i/wbs_we_i in 1; wbs_sel_i in 4; wbs_dat_i/wbs_adr_i in 32; wbs_ack_o out 1; wbs_dat_o out 32.
REQ-007 SHALL have logic-analyser ports: la_data_in in 128; la_data_out out 128; la_oenb in 128.
REQ-008 SHALL have pad ports: io_in in BITS (unused); io_out out BITS; io_oeb out BITS.
REQ-009 SHALL have port irq, output, 3 bits.
REQ-010 SHALL have core ports: core_instr_o out BITS; core_run_o out 1; core_done_i in 1; core_dout_i in BITS.

Function
REQ-011 SHALL decode a hit as cyc&stb with wbs_adr_i[31:8]==ADDR_BASE[31:8]; word offsets: 0x00 CTRL RW, 0x04 STATUS, 0x08 INSTR WO, 0x0C RESULT RO, 0x10 IO_OUT RW.
REQ-012 SHALL assert wbs_ack_o as a one-cycle pulse the cycle after a hit, and SHALL NOT ack in the cycle immediately after an ack.
REQ-013 SHALL NOT ack a miss; an unmapped in-window offset SHALL ack with read data 0 and no side effect.
REQ-014 SHALL apply CTRL and IO_OUT writes per byte lane according to wbs_sel_i; wbs_dat_o bits above the register width SHALL read 0.
REQ-015 SHALL define CTRL bit0 as enable, bit1 as irq_en, and bit2 as io_drive.
REQ-016 SHALL define STATUS as: bit0 instr-full, bit1 instr-empty, bit2 result-empty, bit3 busy, bit4 result-overflow (sticky), bit5 instr-overflow (sticky), [11:8] instr count; a write of 1 to bit4 or bit5 SHALL clear that bit.
REQ-017 SHALL push wbs_dat_i[BITS-1:0] into the instruction FIFO on an INSTR write with wbs_sel_i!=0; a push when full SHALL be dropped and SHALL set STATUS bit5.
REQ-018 SHALL pop the result FIFO on a RESULT read and return the head; a read when empty SHALL return 0 and change no state.
REQ-019 SHALL run the dispatch FSM IDLE->ISSUE->WAIT->IDLE.
REQ-020 In IDLE, when enable=1 and the instruction FIFO is non-empty, SHALL pop the FIFO into core_instr_o and go to ISSUE.
REQ-021 In ISSUE, SHALL drive core_run_o=1 for exactly one cycle, then go to WAIT.
REQ-022 In WAIT, on core_done_i=1, SHALL push core_dout_i into the result FIFO (or drop it and set STATUS bit4 if full), then go to IDLE.
REQ-023 Clearing enable mid-operation SHALL let the current instruction complete and SHALL block further issue.
REQ-024 SHALL hold core_instr_o stable from ISSUE until return to IDLE; busy SHALL be 1 whenever state!=IDLE.
REQ-025 SHALL drive io_out=IO_OUT and io_oeb={BITS{~io_drive}}.
REQ-026 SHALL drive irq[0]=irq_en & ~result-empty, irq[1]=irq_en & (STATUS bit4 | bit5), and irq[2]=0.
REQ-027 SHALL give precedence to a Wishbone RESULT pop over an FSM result push in the same cycle, then apply the push (count unchanged when both occur).

Reset
REQ-028 While wb_rst_i=1 SHALL force: FSM to IDLE, both FIFOs empty, CTRL=0, IO_OUT=0, sticky bits=0, wbs_ack_o=0, core_run_o=0, core_instr_o=0, io_oeb all 1, irq=0.
REQ-029 Reset asserted mid-operation SHALL abandon the in-flight instruction; a core_done_i received after reset SHALL be ignored in IDLE.

Configuration
REQ-030 With macro BITTY_LA_DEBUG_EN defined, SHALL drive la_data_out[BITS-1:0] with the last core_dout_i captured and la_data_out[BITS+1:BITS] with the FSM state.
REQ-031 With BITTY_LA_DEBUG_EN defined, la_oenb[65]=0 with la_data_in[65]=1 SHALL hold the FSM in IDLE.
REQ-032 Without BITTY_LA_DEBUG_EN, la_data_out SHALL be 0 and all LA inputs SHALL be ignored.

Structure
REQ-033 SHALL place register offsets, CTRL/STATUS bit positions and the FSM state encoding in package bitty_pkg.
REQ-034 SHALL implement both FIFOs as instances of one sub-module, bitty_fifo, parameterised by width and depth, exposing full, empty and count.

Verification
REQ-035 Write CTRL=1, then INSTR=0x0012 -> core_run_o pulses once with core_instr_o=0x0012; core_done_i with core_dout_i=0x0034 -> RESULT read returns 0x0034, and the next read returns 0.
REQ-036 With enable=0, push 5 instructions at FIFO_DEPTH=4 -> STATUS[11:8]=4, bit0=1, bit5=1; writing 0x20 to STATUS -> bit5=0.
REQ-037 Fill the result FIFO (4 entries) and complete a fifth instruction -> STATUS bit4=1, irq[1]=1 when irq_en=1, and the FIFO contents are unchanged.
REQ-038 Clear enable while in WAIT -> the done result is still captured, and no new core_run_o pulse occurs even with the instruction FIFO non-empty.
REQ-039 Assert wb_rst_i during WAIT -> outputs reach reset values immediately (asynchronously), and a later core_done_i produces no result.
REQ-040 Access to address 0x3000_0100 -> no ack; access to offset 0x20 -> ack with data 0.

Source files
------------

// File: rtl/bitty_pkg.sv
// Shared definitions for the bitty Wishbone bridge: register map, CTRL/STATUS
// bit positions and the dispatch FSM encoding.
package bitty_pkg;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_INSTR  = 8'h08;
  localparam logic [7:0] OFF_RESULT = 8'h0C;
  localparam logic [7:0] OFF_IO_OUT = 8'h10;

  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int CTRL_IO_DRIVE = 2;
  localparam int CTRL_W        = 3;

  localparam int ST_INSTR_FULL   = 0;
  localparam int ST_INSTR_EMPTY  = 1;
  localparam int ST_RESULT_EMPTY = 2;
  localparam int ST_BUSY         = 3;
  localparam int ST_RESULT_OVF   = 4;
  localparam int ST_INSTR_OVF    = 5;
  localparam int ST_COUNT_LSB    = 8;

  typedef enum logic [1:0] {
    FSM_IDLE  = 2'd0,
    FSM_ISSUE = 2'd1,
    FSM_WAIT  = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/bitty_fifo.sv
// Show-ahead synchronous FIFO used for both the instruction and result queues.
// A pop in the same cycle as a push to a full FIFO frees the slot for that push.
module bitty_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_ok, push_ok;

  assign empty  = (count_q == '0);
  assign full   = (count_q == CW'(DEPTH));
  assign count  = count_q;
  assign head   = mem_q[rd_ptr_q];

  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    count_d  = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; count gates every read of stale entries.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/bitty_wb_bridge.sv
// Wishbone slave that queues instructions for a bitty core and collects results.
// Define BITTY_LA_DEBUG_EN to expose core result/FSM state on the LA and allow an LA issue hold.
module bitty_wb_bridge
  import bitty_pkg::*;
#(
  parameter int          BITS       = 16,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] ADDR_BASE  = 32'h3000_0000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_dat_i,
  input  logic [31:0]       wbs_adr_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic [127:0]      la_data_in,
  output logic [127:0]      la_data_out,
  input  logic [127:0]      la_oenb,
  input  logic [BITS-1:0]   io_in,
  output logic [BITS-1:0]   io_out,
  output logic [BITS-1:0]   io_oeb,
  output logic [2:0]        irq,
  output logic [BITS-1:0]   core_instr_o,
  output logic              core_run_o,
  input  logic              core_done_i,
  input  logic [BITS-1:0]   core_dout_i
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fsm_state_t        state_q, state_d;
  logic [BITS-1:0]   instr_q, instr_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [BITS-1:0]   io_out_q, io_out_d;
  logic              res_ovf_q, res_ovf_d;
  logic              instr_ovf_q, instr_ovf_d;
  logic              ack_q, ack_d;
  logic [31:0]       dat_q, dat_d;

  logic              hit, accept;
  logic [7:0]        off;
  logic [31:0]       lane_mask;
  logic [31:0]       rdata;
  logic [31:0]       status_word;
  logic [31:0]       instr_count_ext;
  logic              la_hold;

  logic              instr_push, instr_pop, instr_full, instr_empty;
  logic [BITS-1:0]   instr_head;
  logic [CW-1:0]     instr_count;
  logic              res_push, res_pop, res_full, res_empty;
  logic [BITS-1:0]   res_head;
  logic [CW-1:0]     res_count;

  assign hit    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == ADDR_BASE[31:8]);
  // The ack cycle blocks a second accept while the master still holds stb.
  assign accept = hit & ~ack_q;
  assign off    = wbs_adr_i[7:0];

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_mask[8*gi +: 8] = {8{wbs_sel_i[gi]}};
  end

  assign instr_push = accept & wbs_we_i & (off == OFF_INSTR) & (|wbs_sel_i);
  assign res_pop    = accept & ~wbs_we_i & (off == OFF_RESULT) & ~res_empty;

  bitty_fifo #(.WIDTH(BITS), .DEPTH(FIFO_DEPTH)) u_instr_fifo (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .push      (instr_push),
    .push_data (wbs_dat_i[BITS-1:0]),
    .pop       (instr_pop),
    .head      (instr_head),
    .full      (instr_full),
    .empty     (instr_empty),
    .count     (instr_count)
  );

  bitty_fifo #(.WIDTH(BITS), .DEPTH(FIFO_DEPTH)) u_result_fifo (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .push      (res_push),
    .push_data (core_dout_i),
    .pop       (res_pop),
    .head      (res_head),
    .full      (res_full),
    .empty     (res_empty),
    .count     (res_count)
  );

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    instr_pop = 1'b0;
    res_push  = 1'b0;
    case (state_q)
      FSM_IDLE: begin
        if (ctrl_q[CTRL_ENABLE] && !instr_empty && !la_hold) begin
          instr_pop = 1'b1;
          instr_d   = instr_head;
          state_d   = FSM_ISSUE;
        end
      end
      FSM_ISSUE: state_d = FSM_WAIT;
      FSM_WAIT: begin
        if (core_done_i) begin
          res_push = 1'b1;
          state_d  = FSM_IDLE;
        end
      end
      default: state_d = FSM_IDLE;
    endcase
  end

  assign instr_count_ext = 32'(instr_count);

  always_comb begin
    status_word                        = '0;
    status_word[ST_INSTR_FULL]         = instr_full;
    status_word[ST_INSTR_EMPTY]        = instr_empty;
    status_word[ST_RESULT_EMPTY]       = res_empty;
    status_word[ST_BUSY]               = (state_q != FSM_IDLE);
    status_word[ST_RESULT_OVF]         = res_ovf_q;
    status_word[ST_INSTR_OVF]          = instr_ovf_q;
    status_word[ST_COUNT_LSB +: 4]     = instr_count_ext[3:0];
  end

  always_comb begin
    ctrl_d      = ctrl_q;
    io_out_d    = io_out_q;
    res_ovf_d   = res_ovf_q;
    instr_ovf_d = instr_ovf_q;
    rdata       = '0;
    ack_d       = accept;
    dat_d       = '0;
    if (accept) begin
      case (off)
        OFF_CTRL: begin
          rdata = 32'(ctrl_q);
          if (wbs_we_i && wbs_sel_i[0]) ctrl_d = wbs_dat_i[CTRL_W-1:0];
        end
        OFF_STATUS: begin
          rdata = status_word;
          if (wbs_we_i && wbs_sel_i[0]) begin
            if (wbs_dat_i[ST_RESULT_OVF]) res_ovf_d   = 1'b0;
            if (wbs_dat_i[ST_INSTR_OVF])  instr_ovf_d = 1'b0;
          end
        end
        OFF_RESULT: begin
          if (!res_empty) rdata = 32'(res_head);
        end
        OFF_IO_OUT: begin
          rdata = 32'(io_out_q);
          if (wbs_we_i)
            io_out_d = (io_out_q & ~lane_mask[BITS-1:0]) |
                       (wbs_dat_i[BITS-1:0] & lane_mask[BITS-1:0]);
        end
        default: rdata = '0;
      endcase
      dat_d = wbs_we_i ? 32'h0 : rdata;
    end
    // New overflow events win over a same-cycle clear.
    if (instr_push && instr_full && !instr_pop) instr_ovf_d = 1'b1;
    if (res_push && res_full && !res_pop)       res_ovf_d   = 1'b1;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= FSM_IDLE;
      instr_q     <= '0;
      ctrl_q      <= '0;
      io_out_q    <= '0;
      res_ovf_q   <= 1'b0;
      instr_ovf_q <= 1'b0;
      ack_q       <= 1'b0;
      dat_q       <= '0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      ctrl_q      <= ctrl_d;
      io_out_q    <= io_out_d;
      res_ovf_q   <= res_ovf_d;
      instr_ovf_q <= instr_ovf_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
    end
  end

  assign wbs_ack_o    = ack_q;
  assign wbs_dat_o    = dat_q;
  assign core_instr_o = instr_q;
  assign core_run_o   = (state_q == FSM_ISSUE);
  assign io_out       = io_out_q;
  assign io_oeb       = {BITS{~ctrl_q[CTRL_IO_DRIVE]}};
  assign irq          = {1'b0,
                         ctrl_q[CTRL_IRQ_EN] & (res_ovf_q | instr_ovf_q),
                         ctrl_q[CTRL_IRQ_EN] & ~res_empty};

`ifdef BITTY_LA_DEBUG_EN
  logic [BITS-1:0] last_dout_q, last_dout_d;
  logic [127:0]    la_out;

  always_comb begin
    last_dout_d = last_dout_q;
    if (res_push) last_dout_d = core_dout_i;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) last_dout_q <= '0;
    else          last_dout_q <= last_dout_d;
  end

  always_comb begin
    la_out                  = '0;
    la_out[BITS-1:0]        = last_dout_q;
    la_out[BITS+1:BITS]     = state_q;
  end

  assign la_data_out = la_out;
  assign la_hold     = ~la_oenb[65] & la_data_in[65];
`else
  assign la_data_out = '0;
  assign la_hold     = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = &{1'b0, io_in, la_data_in, la_oenb, wbs_dat_i, wbs_adr_i,
                       lane_mask, instr_count_ext, res_count};

endmodule

// File: tb/tb_bitty_wb_bridge.sv
// Scoreboard bench for bitty_wb_bridge: stimulus queues expected Wishbone read
// data and expected core issues; monitors compare on ack and core_run_o.
module tb_bitty_wb_bridge;

  localparam int          BITS = 16;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic              wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]        wbs_sel_i;
  logic [31:0]       wbs_dat_i, wbs_adr_i;
  logic              wbs_ack_o;
  logic [31:0]       wbs_dat_o;
  logic [127:0]      la_data_in, la_data_out, la_oenb;
  logic [BITS-1:0]   io_in, io_out, io_oeb;
  logic [2:0]        irq;
  logic [BITS-1:0]   core_instr_o;
  logic              core_run_o;
  logic              core_done_i;
  logic [BITS-1:0]   core_dout_i;

  int checks = 0;
  int errors = 0;

  string           exp_name_q[$];
  logic [31:0]     exp_data_q[$];
  logic [BITS-1:0] run_q[$];
  logic [BITS-1:0] last_instr;

  bitty_wb_bridge #(.BITS(BITS), .FIFO_DEPTH(4), .ADDR_BASE(BASE)) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .wbs_stb_i    (wbs_stb_i),
    .wbs_cyc_i    (wbs_cyc_i),
    .wbs_we_i     (wbs_we_i),
    .wbs_sel_i    (wbs_sel_i),
    .wbs_dat_i    (wbs_dat_i),
    .wbs_adr_i    (wbs_adr_i),
    .wbs_ack_o    (wbs_ack_o),
    .wbs_dat_o    (wbs_dat_o),
    .la_data_in   (la_data_in),
    .la_data_out  (la_data_out),
    .la_oenb      (la_oenb),
    .io_in        (io_in),
    .io_out       (io_out),
    .io_oeb       (io_oeb),
    .irq          (irq),
    .core_instr_o (core_instr_o),
    .core_run_o   (core_run_o),
    .core_done_i  (core_done_i),
    .core_dout_i  (core_dout_i)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: Wishbone acks and core issues.
  initial begin
    string       nm;
    logic [31:0] ed;
    logic [BITS-1:0] ei;
    forever begin
      @(negedge clk);
      if (wbs_ack_o === 1'b1) begin
        if (exp_data_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got ack with data 0x%08h, expected no ack", wbs_dat_o);
        end else begin
          nm = exp_name_q.pop_front();
          ed = exp_data_q.pop_front();
          $display("txn %s: dat_o=0x%08h exp=0x%08h", nm, wbs_dat_o, ed);
          check(nm, wbs_dat_o, ed);
        end
      end
      if (core_run_o === 1'b1) begin
        if (run_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_run: got run with instr 0x%04h, expected no run", core_instr_o);
        end else begin
          ei = run_q.pop_front();
          $display("run: instr=0x%04h exp=0x%04h", core_instr_o, ei);
          check("run_instr", 32'(core_instr_o), 32'(ei));
        end
      end
    end
  end

  task automatic wb(input string name, input logic we, input logic [7:0] off,
                    input logic [31:0] data, input logic [3:0] sel, input logic [31:0] exp);
    bit got = 0;
    exp_name_q.push_back(name);
    exp_data_q.push_back(we ? 32'h0 : exp);
    @(posedge clk); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = BASE | {24'h0, off}; wbs_dat_i = data; wbs_sel_i = sel;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (wbs_ack_o) begin got = 1; break; end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no ack, expected ack within 20 cycles", name);
      void'(exp_name_q.pop_back());
      void'(exp_data_q.pop_back());
    end
  endtask

  task automatic wr(input string name, input logic [7:0] off, input logic [31:0] data);
    wb(name, 1'b1, off, data, 4'hF, 32'h0);
  endtask

  task automatic rd(input string name, input logic [7:0] off, input logic [31:0] exp);
    wb(name, 1'b0, off, 32'h0, 4'hF, exp);
  endtask

  task automatic wb_noack(input string name, input logic [31:0] addr);
    int acks = 0;
    @(posedge clk); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = addr; wbs_sel_i = 4'hF;
    repeat (6) begin
      @(posedge clk); #1;
      if (wbs_ack_o) acks++;
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    check(name, 32'(acks), 32'h0);
  endtask

  // Master holds stb across the ack: acks must be spaced by an idle cycle.
  task automatic hold_read(input logic [7:0] off, input logic [31:0] exp);
    logic [3:0] pattern;
    exp_name_q.push_back("hold_rd_a"); exp_data_q.push_back(exp);
    exp_name_q.push_back("hold_rd_b"); exp_data_q.push_back(exp);
    @(posedge clk); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = BASE | {24'h0, off}; wbs_sel_i = 4'hF;
    for (int i = 3; i >= 0; i--) begin
      @(posedge clk); #1;
      pattern[i] = wbs_ack_o;
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    check("ack_spacing", 32'(pattern), 32'h0000_000A);
  endtask

  task automatic expect_run(input logic [BITS-1:0] ins);
    run_q.push_back(ins);
    last_instr = ins;
  endtask

  task automatic wait_run(input string name);
    bit got = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (core_run_o) begin got = 1; break; end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s: got no core_run_o, expected a pulse within 20 cycles", name);
    end
  endtask

  task automatic pulse_done(input logic [BITS-1:0] dout);
    @(posedge clk); #1;
    check("instr_hold", 32'(core_instr_o), 32'(last_instr));
    core_done_i = 1'b1; core_dout_i = dout;
    @(posedge clk); #1;
    core_done_i = 1'b0; core_dout_i = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"},   32'(wbs_ack_o),    32'h0);
    check({tag, "_run"},   32'(core_run_o),   32'h0);
    check({tag, "_instr"}, 32'(core_instr_o), 32'h0);
    check({tag, "_oeb"},   32'(io_oeb),       32'h0000_FFFF);
    check({tag, "_ioout"}, 32'(io_out),       32'h0);
    check({tag, "_irq"},   32'(irq),          32'h0);
    check({tag, "_la"},    32'(la_data_out[31:0]), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected completion before 500us");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0; wbs_sel_i = 0; wbs_dat_i = 0; wbs_adr_i = 0;
    la_data_in = '0; la_oenb = '1; io_in = '0;
    core_done_i = 0; core_dout_i = '0; last_instr = '0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst0");
    rst = 1'b0;

    rd("status_reset", 8'h04, 32'h0000_0006);
    rd("ctrl_reset",   8'h00, 32'h0);

    // Basic dispatch and result return
    wr("ctrl_en", 8'h00, 32'h1);
    expect_run(16'h0012);
    wr("instr_12", 8'h08, 32'h0000_0012);
    wait_run("run_12");
    rd("status_busy", 8'h04, 32'h0000_000E);
    pulse_done(16'h0034);
    rd("result_34",    8'h0C, 32'h0000_0034);
    rd("result_empty", 8'h0C, 32'h0);
    rd("status_idle",  8'h04, 32'h0000_0006);

    // IO_OUT byte lanes and pad enables
    wr("io_all", 8'h10, 32'hFFFF_FFFF);
    rd("io_all_rd", 8'h10, 32'h0000_FFFF);
    wr("io_abcd", 8'h10, 32'h0000_ABCD);
    wb("io_lane0", 1'b1, 8'h10, 32'h0000_1234, 4'b0001, 32'h0);
    rd("io_lane0_rd", 8'h10, 32'h0000_AB34);
    wb("io_lane1", 1'b1, 8'h10, 32'hFFFF_5678, 4'b0010, 32'h0);
    wb("io_lane2", 1'b1, 8'h10, 32'h0099_0000, 4'b0100, 32'h0);
    rd("io_lane1_rd", 8'h10, 32'h0000_5634);
    check("io_out_pin", 32'(io_out), 32'h0000_5634);
    check("io_oeb_off", 32'(io_oeb), 32'h0000_FFFF);
    wr("ctrl_drive", 8'h00, 32'h5);
    #1;
    check("io_oeb_on", 32'(io_oeb), 32'h0);
    wb("ctrl_nosel", 1'b1, 8'h00, 32'h0, 4'b0000, 32'h0);
    hold_read(8'h00, 32'h0000_0005);

    // Instruction FIFO overflow with issue disabled
    wr("ctrl_irqen", 8'h00, 32'h2);
    for (int i = 1; i <= 5; i++) wr("instr_fill", 8'h08, 32'h0100 + 32'(i));
    rd("status_ifull", 8'h04, 32'h0000_0425);
    check("irq_iovf", 32'(irq), 32'h2);
    wr("clr_iovf", 8'h04, 32'h20);
    rd("status_iovf_clr", 8'h04, 32'h0000_0405);
    check("irq_clr", 32'(irq), 32'h0);

    // Drain four instructions into a full result FIFO, then overflow it
    for (int i = 1; i <= 4; i++) expect_run(16'h0100 + 16'(i));
    wr("ctrl_run", 8'h00, 32'h3);
    for (int i = 1; i <= 4; i++) begin
      last_instr = 16'h0100 + 16'(i);
      wait_run("run_fill");
      pulse_done(16'h00A0 + 16'(i));
    end
    expect_run(16'h0105);
    wr("instr_105", 8'h08, 32'h0000_0105);
    wait_run("run_105");
    pulse_done(16'h00A5);
    rd("status_rovf", 8'h04, 32'h0000_0012);
    check("irq_rovf", 32'(irq), 32'h3);
    for (int i = 1; i <= 4; i++) rd("result_fill", 8'h0C, 32'h00A0 + 32'(i));
    rd("result_after", 8'h0C, 32'h0);
    rd("status_rovf_e", 8'h04, 32'h0000_0016);
    check("irq_rovf_e", 32'(irq), 32'h2);
    wr("clr_rovf", 8'h04, 32'h10);
    rd("status_rovf_clr", 8'h04, 32'h0000_0006);

    // Disable while waiting: completion captured, no further issue
    wr("ctrl_en2", 8'h00, 32'h1);
    expect_run(16'h0201);
    wr("instr_201", 8'h08, 32'h0000_0201);
    wait_run("run_201");
    wr("instr_202", 8'h08, 32'h0000_0202);
    wr("ctrl_dis", 8'h00, 32'h0);
    rd("status_wait", 8'h04, 32'h0000_010C);
    pulse_done(16'h00B1);
    repeat (10) @(posedge clk);
    rd("status_blocked", 8'h04, 32'h0000_0100);
    rd("result_b1", 8'h0C, 32'h0000_00B1);

    // Asynchronous reset while the core is busy
    wr("io_pre_rst", 8'h10, 32'h0000_00FF);
    expect_run(16'h0202);
    wr("ctrl_en3", 8'h00, 32'h7);
    wait_run("run_202");
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("arst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    last_instr = '0;
    pulse_done(16'h00CC);
    rd("status_post_rst", 8'h04, 32'h0000_0006);
    rd("result_post_rst", 8'h0C, 32'h0);
    rd("ctrl_post_rst",   8'h00, 32'h0);
    rd("io_post_rst",     8'h10, 32'h0);

    // Address decode edges
    wb_noack("miss_0100", 32'h3000_0100);
    rd("unmapped_rd", 8'h20, 32'h0);
    wr("unmapped_wr", 8'h20, 32'hFFFF_FFFF);
    rd("status_unmapped", 8'h04, 32'h0000_0006);

    repeat (5) @(posedge clk);
    check("run_q_drained", 32'(run_q.size()), 32'h0);
    check("sb_drained", 32'(exp_data_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
